// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: builds op_a/op_b and registers them behind a
// valid/ready handshake with a one-beat skid buffer. Optional macro: ALU_OPERAND_FWD_EN.
module alu_operand_stage #(
   parameter int WIDTH  = 16,
   parameter int IMM_W  = 8,
   parameter int REG_AW = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   rs,
   input  logic [WIDTH-1:0]   rq,
   input  logic [WIDTH-1:0]   pc,
   input  logic [IMM_W-1:0]   offset,
   input  logic               a_sel,
   input  logic [1:0]         b_sel,
`ifdef ALU_OPERAND_FWD_EN
   input  logic [REG_AW-1:0]  rs_addr,
   input  logic [REG_AW-1:0]  rq_addr,
   input  logic               fwd_we,
   input  logic [REG_AW-1:0]  fwd_addr,
   input  logic [WIDTH-1:0]   fwd_data,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b
);

   if (IMM_W < 1 || IMM_W >= WIDTH || REG_AW < 1) begin : g_param_check
      $error("alu_operand_stage: illegal IMM_W/WIDTH/REG_AW combination");
   end

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               skid_full_q, skid_full_d;
   logic [WIDTH-1:0]   skid_a_q, skid_a_d;
   logic [WIDTH-1:0]   skid_b_q, skid_b_d;

   logic               accept;
   logic               pop;
   logic [WIDTH-1:0]   rs_eff;
   logic [WIDTH-1:0]   rq_eff;
   logic [WIDTH-1:0]   sext_off;
   logic [WIDTH-1:0]   zext_off;
   logic [WIDTH-1:0]   new_a;
   logic [WIDTH-1:0]   new_b;

   assign in_ready  = ~skid_full_q;
   assign out_valid = out_valid_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;

   assign accept = in_valid & ~skid_full_q;
   assign pop    = out_valid_q & out_ready;

`ifdef ALU_OPERAND_FWD_EN
   assign rs_eff = (fwd_we && fwd_addr == rs_addr) ? fwd_data : rs;
   assign rq_eff = (fwd_we && fwd_addr == rq_addr) ? fwd_data : rq;
`else
   assign rs_eff = rs;
   assign rq_eff = rq;
`endif

   // Operands are finished in the accept cycle so upstream may change afterwards
   always_comb begin
      sext_off = {{(WIDTH-IMM_W){offset[IMM_W-1]}}, offset};
      zext_off = {{(WIDTH-IMM_W){1'b0}}, offset};
      new_a    = a_sel ? pc : rs_eff;
      unique case (b_sel)
         2'b00:   new_b = rq_eff;
         2'b01:   new_b = sext_off;
         2'b10:   new_b = zext_off;
         default: new_b = {sext_off[WIDTH-2:0], 1'b0};
      endcase
   end

   // Main register refills from the skid first to keep FIFO order
   always_comb begin
      out_valid_d = out_valid_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      skid_full_d = skid_full_q;
      skid_a_d    = skid_a_q;
      skid_b_d    = skid_b_q;
      if (!out_valid_q || pop) begin
         if (skid_full_q) begin
            out_valid_d = 1'b1;
            op_a_d      = skid_a_q;
            op_b_d      = skid_b_q;
            skid_full_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            op_a_d      = new_a;
            op_b_d      = new_b;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_full_d = 1'b1;
         skid_a_d    = new_a;
         skid_b_d    = new_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         skid_full_q <= 1'b0;
         skid_a_q    <= '0;
         skid_b_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         skid_full_q <= skid_full_d;
         skid_a_q    <= skid_a_d;
         skid_b_q    <= skid_b_d;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (WIDTH=16, IMM_W=8).
// Forwarding checks are compiled in only when ALU_OPERAND_FWD_EN is defined.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] rs;
   logic [15:0] rq;
   logic [15:0] pc;
   logic [7:0]  offset;
   logic        a_sel;
   logic [1:0]  b_sel;
`ifdef ALU_OPERAND_FWD_EN
   logic [2:0]  rs_addr;
   logic [2:0]  rq_addr;
   logic        fwd_we;
   logic [2:0]  fwd_addr;
   logic [15:0] fwd_data;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.WIDTH(16), .IMM_W(8), .REG_AW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs        (rs),
      .rq        (rq),
      .pc        (pc),
      .offset    (offset),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
`ifdef ALU_OPERAND_FWD_EN
      .rs_addr   (rs_addr),
      .rq_addr   (rq_addr),
      .fwd_we    (fwd_we),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op_a      (op_a),
      .op_b      (op_b)
   );

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      rs = 16'hDEAD; rq = 16'hBEEF; pc = 16'h1234; offset = 8'h55;
      a_sel = 1'b0; b_sel = 2'b00;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", out_valid);
      else passed++;
      checks++;
      if (op_a !== 16'h0000) $display("[TB] FAIL reset_op_a got %h want 0000", op_a);
      else passed++;
      checks++;
      if (op_b !== 16'h0000) $display("[TB] FAIL reset_op_b got %h want 0000", op_b);
      else passed++;
      checks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_register_operands();
      rs = 16'h2182; rq = 16'h049D; a_sel = 1'b0; b_sel = 2'b00;
      out_ready = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; rs = 16'h0000; rq = 16'hFFFF;
      checks++;
      if (out_valid !== 1'b1 || op_a !== 16'h2182 || op_b !== 16'h049D)
         $display("[TB] FAIL reg_beat got v=%b a=%h b=%h want v=1 a=2182 b=049D",
                  out_valid, op_a, op_b);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b0 || op_a !== 16'h2182 || op_b !== 16'h049D)
         $display("[TB] FAIL reg_drain got v=%b a=%h b=%h want v=0 a=2182 b=049D",
                  out_valid, op_a, op_b);
      else passed++;
   endtask

   task automatic test_offset_modes();
      logic [7:0]  v_off [7] = '{8'h24, 8'h94, 8'h94, 8'h94, 8'h94, 8'h80, 8'h7F};
      logic [1:0]  v_bs  [7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11};
      logic        v_as  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [15:0] v_ea  [7] = '{16'h1111, 16'h1111, 16'h1111, 16'h1111,
                                 16'h0100, 16'h0100, 16'h1111};
      logic [15:0] v_eb  [7] = '{16'h0024, 16'hFF94, 16'h0094, 16'hFF28,
                                 16'h2222, 16'hFF00, 16'h00FE};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         rs = 16'h1111; rq = 16'h2222; pc = 16'h0100;
         offset = v_off[i]; b_sel = v_bs[i]; a_sel = v_as[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0; offset = 8'h00; pc = 16'h0000;
         checks++;
         if (out_valid !== 1'b1 || op_a !== v_ea[i] || op_b !== v_eb[i])
            $display("[TB] FAIL offset_vec%0d got v=%b a=%h b=%h want v=1 a=%h b=%h",
                     i, out_valid, op_a, op_b, v_ea[i], v_eb[i]);
         else passed++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; a_sel = 1'b0; b_sel = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || op_a !== 16'h0A00 + 16'(i - 1) ||
                op_b !== 16'h0B00 + 16'(i - 1) || in_ready !== 1'b1)
               $display("[TB] FAIL b2b_beat%0d got v=%b r=%b a=%h b=%h want v=1 r=1 a=%h b=%h",
                        i - 1, out_valid, in_ready, op_a, op_b,
                        16'h0A00 + 16'(i - 1), 16'h0B00 + 16'(i - 1));
            else passed++;
         end
         if (i < 3) begin
            rs = 16'h0A00 + 16'(i); rq = 16'h0B00 + 16'(i); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL b2b_empty got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_stall_skid();
      out_ready = 1'b0; a_sel = 1'b0; b_sel = 2'b00;
      rs = 16'hAAA1; rq = 16'hAAA2; in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || op_a !== 16'hAAA1 || in_ready !== 1'b1)
         $display("[TB] FAIL stall_a got v=%b r=%b a=%h want v=1 r=1 a=AAA1",
                  out_valid, in_ready, op_a);
      else passed++;
      rs = 16'hBBB1; b_sel = 2'b01; offset = 8'h80;
      tick();
      checks++;
      if (in_ready !== 1'b0 || op_a !== 16'hAAA1 || op_b !== 16'hAAA2)
         $display("[TB] FAIL stall_skid got r=%b a=%h b=%h want r=0 a=AAA1 b=AAA2",
                  in_ready, op_a, op_b);
      else passed++;
      rs = 16'hCCC1; rq = 16'hCCC2; b_sel = 2'b00; offset = 8'h00;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_a !== 16'hAAA1)
         $display("[TB] FAIL stall_hold got r=%b v=%b a=%h want r=0 v=1 a=AAA1",
                  in_ready, out_valid, op_a);
      else passed++;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || op_a !== 16'hBBB1 || op_b !== 16'hFF80 || in_ready !== 1'b1)
         $display("[TB] FAIL stall_b got v=%b r=%b a=%h b=%h want v=1 r=1 a=BBB1 b=FF80",
                  out_valid, in_ready, op_a, op_b);
      else passed++;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || op_a !== 16'hCCC1 || op_b !== 16'hCCC2)
         $display("[TB] FAIL stall_c got v=%b a=%h b=%h want v=1 a=CCC1 b=CCC2",
                  out_valid, op_a, op_b);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL stall_drain got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0; a_sel = 1'b0; b_sel = 2'b00;
      rs = 16'hD001; rq = 16'hD002; in_valid = 1'b1;
      tick();
      rs = 16'hE001; rq = 16'hE002;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("[TB] FAIL full_before_rst got r=%b v=%b want r=0 v=1", in_ready, out_valid);
      else passed++;
      rst = 1'b1; out_ready = 1'b1; rs = 16'hF001;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== 16'h0000 || op_b !== 16'h0000)
         $display("[TB] FAIL full_rst got v=%b r=%b a=%h b=%h want v=0 r=1 a=0000 b=0000",
                  out_valid, in_ready, op_a, op_b);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b0 || op_a !== 16'h0000)
         $display("[TB] FAIL full_lost got v=%b a=%h want v=0 a=0000", out_valid, op_a);
      else passed++;
   endtask

`ifdef ALU_OPERAND_FWD_EN
   task automatic test_forwarding();
      logic       v_we   [3] = '{1'b1, 1'b1, 1'b0};
      logic [2:0] v_addr [3] = '{3'd3, 3'd4, 3'd3};
      logic [15:0] v_ea  [3] = '{16'hBEEF, 16'h1357, 16'h1357};
      out_ready = 1'b1; a_sel = 1'b0; b_sel = 2'b00;
      rs = 16'h1357; rq = 16'h2468; rs_addr = 3'd3; rq_addr = 3'd5;
      fwd_data = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         fwd_we = v_we[i]; fwd_addr = v_addr[i]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0; fwd_we = 1'b0;
         checks++;
         if (op_a !== v_ea[i] || op_b !== 16'h2468 || out_valid !== 1'b1)
            $display("[TB] FAIL fwd_vec%0d got v=%b a=%h b=%h want v=1 a=%h b=2468",
                     i, out_valid, op_a, op_b, v_ea[i]);
         else passed++;
         tick();
      end
   endtask
`endif

   initial begin
`ifdef ALU_OPERAND_FWD_EN
      rs_addr = '0; rq_addr = '0; fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
`endif
      test_reset();
      test_register_operands();
      test_offset_modes();
      test_back_to_back();
      test_stall_skid();
      test_reset_full();
`ifdef ALU_OPERAND_FWD_EN
      test_forwarding();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
